// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared widths, fixed-point constants and FSM states for the LSTM cell-state stage
package lstm_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int FRAC_DEF  = 20;

   localparam logic [31:0] FXP_ONE = 32'h0010_0000;
   localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MUL_FC,
      S_MUL_IG,
      S_SUM,
      S_OUT
   } state_t;

endpackage

// File: rtl/fxp_mul.sv
// rtl/fxp_mul.sv - signed WIDTHxWIDTH multiply rescaled by FRAC (floor); saturates when LSTM_CELL_SAT_EN is defined
module fxp_mul #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 20
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] p,
   output logic             ovf
);

   logic [2*WIDTH-1:0] prod;

   assign prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

`ifdef LSTM_CELL_SAT_EN
   logic [WIDTH-FRAC:0] top_bits;
   logic                unused_bits;

   // The kept field plus everything above it must be a pure sign extension.
   assign top_bits    = prod[2*WIDTH-1:FRAC+WIDTH-1];
   assign ovf         = !((&top_bits) || (~|top_bits));
   assign unused_bits = ^prod[FRAC-1:0];

   always_comb begin
      p = prod[FRAC+WIDTH-1:FRAC];
      if (ovf) begin
         p = prod[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   logic unused_bits;

   assign p           = prod[FRAC+WIDTH-1:FRAC];
   assign ovf         = 1'b0;
   assign unused_bits = ^{prod[2*WIDTH-1:FRAC+WIDTH], prod[FRAC-1:0]};
`endif

endmodule

// File: rtl/lstm_cell_state.sv
// rtl/lstm_cell_state.sv - c_t = f*c_{t-1} + i*g, one element per handshake, with an internal c memory
// Optional macro LSTM_CELL_SAT_EN: saturate products and the final sum instead of wrapping.
module lstm_cell_state
   import lstm_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int FRAC     = FRAC_DEF,
   parameter int NUM_CELL = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_start,
   input  logic                        i_clear,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [WIDTH-1:0]            i_f,
   input  logic [WIDTH-1:0]            i_i,
   input  logic [WIDTH-1:0]            i_g,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [WIDTH-1:0]            o_c,
   output logic [$clog2(NUM_CELL)-1:0] o_idx,
   output logic                        o_done
);

   localparam int IW = $clog2(NUM_CELL);

   state_t           state, state_nxt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] f_r, i_r, g_r;
   logic [WIDTH-1:0] p_fc, p_ig;
   logic [WIDTH-1:0] mem [NUM_CELL];
   logic [WIDTH-1:0] mul_a, mul_b, mul_p;
   logic [WIDTH-1:0] sum_raw, sum_c;
   logic             mul_ovf_unused;
   logic             last;

   assign last  = (idx == IW'(NUM_CELL - 1));
   assign o_idx = idx;

   // One multiplier serves both products; operands switch with the state.
   assign mul_a = (state == S_MUL_FC) ? f_r      : i_r;
   assign mul_b = (state == S_MUL_FC) ? mem[idx] : g_r;

   fxp_mul #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_mul (
      .a   (mul_a),
      .b   (mul_b),
      .p   (mul_p),
      .ovf (mul_ovf_unused)
   );

   assign sum_raw = p_fc + p_ig;

`ifdef LSTM_CELL_SAT_EN
   logic sum_ovf;

   assign sum_ovf = (p_fc[WIDTH-1] == p_ig[WIDTH-1]) && (sum_raw[WIDTH-1] != p_fc[WIDTH-1]);
   assign sum_c   = !sum_ovf ? sum_raw :
                    p_fc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign sum_c = sum_raw;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      o_ready   = 1'b0;
      o_valid   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!i_clear && i_start) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            o_ready = 1'b1;
            if (i_valid) begin
               state_nxt = S_MUL_FC;
            end
         end
         S_MUL_FC: state_nxt = S_MUL_IG;
         S_MUL_IG: state_nxt = S_SUM;
         S_SUM:    state_nxt = S_OUT;
         S_OUT: begin
            o_valid = 1'b1;
            if (i_ready) begin
               state_nxt = last ? S_IDLE : S_LOAD;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         f_r    <= '0;
         i_r    <= '0;
         g_r    <= '0;
         p_fc   <= '0;
         p_ig   <= '0;
         o_c    <= '0;
         o_done <= 1'b0;
         for (int k = 0; k < NUM_CELL; k++) begin
            mem[k] <= '0;
         end
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_clear) begin
                  for (int k = 0; k < NUM_CELL; k++) begin
                     mem[k] <= '0;
                  end
               end else if (i_start) begin
                  idx <= '0;
               end
            end
            S_LOAD: begin
               if (i_valid) begin
                  f_r <= i_f;
                  i_r <= i_i;
                  g_r <= i_g;
               end
            end
            S_MUL_FC: p_fc <= mul_p;
            S_MUL_IG: p_ig <= mul_p;
            S_SUM:    o_c  <= sum_c;
            S_OUT: begin
               // Write-back only on the output handshake, so a stalled element leaves memory intact.
               if (i_ready) begin
                  mem[idx] <= o_c;
                  if (last) begin
                     o_done <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lstm_cell_state.sv
// tb/tb_lstm_cell_state.sv - table-driven scoreboard bench for lstm_cell_state
module tb_lstm_cell_state;
   import lstm_pkg::*;

   localparam int NC = 8;
   localparam logic [31:0] HALF = 32'h0008_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_start, i_clear, i_valid, i_ready;
   logic        o_ready, o_valid, o_done;
   logic [31:0] i_f, i_i, i_g, o_c;
   logic [2:0]  o_idx;

   typedef struct {
      logic [31:0] f;
      logic [31:0] i;
      logic [31:0] g;
      logic [31:0] exp;
      int          bp_elem;
      int          inj_elem;
   } vec_t;

   typedef struct {
      logic [2:0]  idx;
      logic [31:0] c;
   } exp_t;

   vec_t tbl [8];
   exp_t sb [$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   lstm_cell_state dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (i_start),
      .i_clear (i_clear),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_f     (i_f),
      .i_i     (i_i),
      .i_g     (i_g),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_c     (o_c),
      .o_idx   (o_idx),
      .o_done  (o_done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_step(input logic [31:0] f, input logic [31:0] gi, input logic [31:0] g,
                           input logic [31:0] exp, input int bp, input int inj);
      int   n;
      int   lat;
      exp_t e_item;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int e = 0; e < NC; e++) begin
         n = 0;
         while (!o_ready && n < 20) begin
            tick();
            n++;
         end
         chk("o_ready_wait", 32'(o_ready), 32'd1);
         i_ready = (e == bp) ? 1'b0 : 1'b1;
         i_valid = 1'b1;
         i_f     = f;
         i_i     = gi;
         i_g     = g;
         sb.push_back('{idx: 3'(e), c: exp});
         tick();
         i_valid = 1'b0;
         lat = 0;
         while (!o_valid && lat < 20) begin
            i_clear = (e == inj) && (lat == 0);
            i_start = (e == inj) && (lat == 0);
            tick();
            lat++;
         end
         i_clear = 1'b0;
         i_start = 1'b0;
         chk("latency", 32'(lat), 32'd3);
         e_item = sb.pop_front();
         chk("o_c", o_c, e_item.c);
         chk("o_idx", 32'(o_idx), 32'(e_item.idx));
         if (e == bp) begin
            for (int s = 0; s < 5; s++) begin
               tick();
               chk("bp_o_c", o_c, e_item.c);
               chk("bp_o_idx", 32'(o_idx), 32'(e_item.idx));
               chk("bp_o_ready", 32'(o_ready), 32'd0);
               chk("bp_o_valid", 32'(o_valid), 32'd1);
            end
            i_ready = 1'b1;
         end
         tick();
         if (e == NC - 1) begin
            chk("o_done_pulse", 32'(o_done), 32'd1);
            chk("idle_o_ready", 32'(o_ready), 32'd0);
            chk("idle_o_valid", 32'(o_valid), 32'd0);
            tick();
            chk("o_done_clear", 32'(o_done), 32'd0);
         end else begin
            chk("o_done_mid", 32'(o_done), 32'd0);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{FXP_ONE, FXP_ONE, FXP_ONE, 32'h0010_0000, -1, -1};
      tbl[1] = '{HALF, HALF, HALF, 32'h000C_0000, 3, -1};
      tbl[2] = '{FXP_ONE, 32'h0, 32'h0000_1234, 32'h000C_0000, -1, -1};
      tbl[3] = '{32'h0, FXP_ONE, 32'h7FF0_0000, 32'h7FF0_0000, -1, -1};
`ifdef LSTM_CELL_SAT_EN
      tbl[4] = '{FXP_ONE, FXP_ONE, 32'h0020_0000, SAT_MAX, -1, -1};
`else
      tbl[4] = '{FXP_ONE, FXP_ONE, 32'h0020_0000, 32'h8010_0000, -1, -1};
`endif
      tbl[5] = '{32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, -1, -1};
      tbl[6] = '{FXP_ONE, FXP_ONE, FXP_ONE, 32'h000F_FFFF, -1, -1};
      tbl[7] = '{FXP_ONE, 32'h0, FXP_ONE, 32'h000F_FFFF, -1, 0};

      rst_n   = 1'b0;
      i_start = 1'b0;
      i_clear = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_f     = '0;
      i_i     = '0;
      i_g     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_o_ready", 32'(o_ready), 32'd0);
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_c", o_c, 32'd0);
      chk("rst_o_idx", 32'(o_idx), 32'd0);
      chk("rst_o_done", 32'(o_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int r = 0; r < 8; r++) begin
         run_step(tbl[r].f, tbl[r].i, tbl[r].g, tbl[r].exp, tbl[r].bp_elem, tbl[r].inj_elem);
      end

      // i_clear wins over i_start in IDLE, then the memory reads back as zero.
      i_clear = 1'b1;
      i_start = 1'b1;
      tick();
      i_clear = 1'b0;
      i_start = 1'b0;
      chk("clear_stays_idle", 32'(o_ready), 32'd0);
      run_step(FXP_ONE, 32'h0, FXP_ONE, 32'h0, -1, -1);

      run_step(FXP_ONE, FXP_ONE, FXP_ONE, FXP_ONE, -1, -1);

      // Asynchronous reset in MUL_IG discards the element and clears memory.
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      i_valid = 1'b1;
      i_f     = FXP_ONE;
      i_i     = FXP_ONE;
      i_g     = FXP_ONE;
      tick();
      i_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_o_valid", 32'(o_valid), 32'd0);
      chk("arst_o_ready", 32'(o_ready), 32'd0);
      chk("arst_o_c", o_c, 32'd0);
      chk("arst_o_idx", 32'(o_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_step(FXP_ONE, 32'h0, FXP_ONE, 32'h0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
